// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and widths for the pipeline hazard controller
package pipeline_ctrl_pkg;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic {RUN, STALL} state_t;
    typedef logic [REG_W-1:0] reg_t;

    // Register 0 is hardwired to zero, so it never creates a dependency
    function automatic logic reg_match(reg_t r, reg_t d);
        return (r == d) && (d != '0);
    endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side signals seen by the hazard controller
interface pipeline_hazard_ctrl_if;
    import pipeline_ctrl_pkg::*;

    reg_t             ID_rs;
    reg_t             ID_rt;
    logic             ID_Branch;
    logic             ID_JumpReg;
    logic             ID_BranchTaken;
    logic             ID_Jump;
    logic             EX_RegWr;
    logic             EX_MemRd;
    reg_t             EX_WrReg;
    logic             MEM_RegWr;
    logic             MEM_MemRd;
    reg_t             MEM_WrReg;
    logic             IRQ;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             ForwardC;
    logic             ForwardD;
    logic             IRQ_Take;
    logic [CNT_W-1:0] StallCnt;

    modport slave (
        input  ID_rs, ID_rt, ID_Branch, ID_JumpReg, ID_BranchTaken, ID_Jump,
        input  EX_RegWr, EX_MemRd, EX_WrReg, MEM_RegWr, MEM_MemRd, MEM_WrReg, IRQ,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, ForwardC, ForwardD,
        output IRQ_Take, StallCnt
    );

    modport master (
        output ID_rs, ID_rt, ID_Branch, ID_JumpReg, ID_BranchTaken, ID_Jump,
        output EX_RegWr, EX_MemRd, EX_WrReg, MEM_RegWr, MEM_MemRd, MEM_WrReg, IRQ,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, ForwardC, ForwardD,
        input  IRQ_Take, StallCnt
    );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: register dependency detection, stall length and ID compare forwarding
module hazard_match
    import pipeline_ctrl_pkg::*;
(
    input  reg_t       id_rs,
    input  reg_t       id_rt,
    input  logic       id_branch,
    input  logic       id_jump_reg,
    input  logic       ex_reg_wr,
    input  logic       ex_mem_rd,
    input  reg_t       ex_wr_reg,
    input  logic       mem_reg_wr,
    input  logic       mem_mem_rd,
    input  reg_t       mem_wr_reg,
    output logic [1:0] stall_len,
    output logic       fwd_c,
    output logic       fwd_d
);
    logic cmp;
    logic ex_hit;
    logic mem_load_hit;
    logic load_use;

    // An ID compare needs its operands a cycle earlier than an ALU consumer, so
    // a load feeding a branch/jr costs two cycles while other dependencies cost one
    always_comb begin
        cmp          = id_branch | id_jump_reg;
        ex_hit       = ex_reg_wr & (reg_match(id_rs, ex_wr_reg) | reg_match(id_rt, ex_wr_reg));
        mem_load_hit = mem_reg_wr & mem_mem_rd &
                       (reg_match(id_rs, mem_wr_reg) | reg_match(id_rt, mem_wr_reg));
        load_use     = ex_hit & ex_mem_rd;
        stall_len    = (cmp & load_use) ? 2'd2 :
                       (load_use | (cmp & (ex_hit | mem_load_hit))) ? 2'd1 : 2'd0;
        fwd_c        = mem_reg_wr & ~mem_mem_rd & reg_match(id_rs, mem_wr_reg);
        fwd_d        = mem_reg_wr & ~mem_mem_rd & reg_match(id_rt, mem_wr_reg);
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward/interrupt control; HAZ_PERF_CNT_EN enables StallCnt
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    state_t     state;
    logic       irq_q;
    logic       irq_pending;
    logic [1:0] stall_len;
    logic       stall;
    logic       redirect;
    logic       take;

    hazard_match u_match (
        .id_rs       (bus.ID_rs),
        .id_rt       (bus.ID_rt),
        .id_branch   (bus.ID_Branch),
        .id_jump_reg (bus.ID_JumpReg),
        .ex_reg_wr   (bus.EX_RegWr),
        .ex_mem_rd   (bus.EX_MemRd),
        .ex_wr_reg   (bus.EX_WrReg),
        .mem_reg_wr  (bus.MEM_RegWr),
        .mem_mem_rd  (bus.MEM_MemRd),
        .mem_wr_reg  (bus.MEM_WrReg),
        .stall_len   (stall_len),
        .fwd_c       (bus.ForwardC),
        .fwd_d       (bus.ForwardD)
    );

    // A fresh hazard stalls in the cycle it is seen; STALL adds the second cycle
    // An interrupt only enters on a clean cycle so it never races a stall or redirect
    always_comb begin
        stall          = (state == STALL) | (stall_len != 2'd0);
        redirect       = bus.ID_BranchTaken | bus.ID_Jump;
        take           = irq_pending & (state == RUN) & ~stall & ~redirect;
        bus.PC_Write   = ~stall;
        bus.IFID_Write = ~stall;
        bus.IFID_Flush = (~stall & redirect) | take;
        bus.IDEX_Flush = stall | take;
        bus.IRQ_Take   = take;
    end

    // Stall FSM plus interrupt edge capture; an edge coinciding with a take stays pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            irq_q       <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            state       <= (state == RUN && stall_len == 2'd2) ? STALL : RUN;
            irq_q       <= bus.IRQ;
            irq_pending <= (irq_pending & ~take) | (bus.IRQ & ~irq_q);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of stall cycles for performance monitoring
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign bus.StallCnt = stall_cnt;
`else
    assign bus.StallCnt = '0;
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-003 SHALL: ID_rs, ID_rt  in  5 each  source register fields of the instruction in ID.
REQ-004 SHALL: ID_Branch  in  1  ID instruction is bltz/beq/bne/blez/bgtz; ID_JumpReg  in  1  ID instruction is jr/jalr.
REQ-005 SHALL: ID_BranchTaken  in  1  branch condition true in ID; ID_Jump  in  1  ID instruction is j/jal/jr/jalr.
REQ-006 SHALL: EX_RegWr, EX_MemRd  in  1 each; EX_WrReg  in  5  destination of the ID/EX instruction.
REQ-007 SHALL: MEM_RegWr, MEM_MemRd  in  1 each; MEM_WrReg  in  5  destination of the EX/MEM instruction.
REQ-008 SHALL: IRQ  in  1  level interrupt request.
REQ-009 SHALL: PC_Write, IFID_Write  out  1 each  1 = advance; IFID_Flush, IDEX_Flush  out  1 each  1 = insert bubble.
REQ-010 SHALL: ForwardC, ForwardD  out  1 each  select MEM-stage result for ID rs/rt compare operands.
REQ-011 SHALL: IRQ_Take  out  1  one-cycle pulse, interrupt accepted; StallCnt  out  16  stall-cycle count.

Function
REQ-012 SHALL: match(r, d) defined as r == d and d != 0; register 0 never matches.
REQ-013 SHALL: load-use hazard = EX_MemRd & EX_RegWr & match(ID_rs|ID_rt, EX_WrReg); stall length 1.
REQ-014 SHALL: compare hazard (ID_Branch|ID_JumpReg) with EX_RegWr & match(ID_rs|ID_rt, EX_WrReg): length 1 if !EX_MemRd, length 2 if EX_MemRd.
REQ-015 SHALL: compare hazard with MEM_MemRd & MEM_RegWr & match(ID_rs|ID_rt, MEM_WrReg): length 1.
REQ-016 SHALL: FSM states RUN, STALL; in RUN a detected hazard stalls the current cycle combinationally; length 2 moves to STALL for exactly one further cycle, then returns to RUN.
REQ-017 SHALL: in STALL, hazard inputs are ignored and the stall is unconditional.
REQ-018 SHALL: stall cycle outputs: PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0; otherwise PC_Write=IFID_Write=1.
REQ-019 SHALL: in a non-stall cycle, IFID_Flush=1 when ID_BranchTaken or ID_Jump; stall has priority over flush.
REQ-020 SHALL: ForwardC = MEM_RegWr & !MEM_MemRd & match(ID_rs, MEM_WrReg); ForwardD likewise with ID_rt; combinational, independent of FSM state.
REQ-021 SHALL: IRQ rising edge (IRQ & !IRQ_q) sets irq_pending; pending stays set until taken.
REQ-022 SHALL: IRQ_Take=1 for one cycle when irq_pending, state RUN, no stall and no branch/jump flush that cycle; IRQ_Take forces IFID_Flush=1 and IDEX_Flush=1 and clears irq_pending next edge.
REQ-023 SHALL: an IRQ edge arriving during a stall or in the same cycle as IRQ_Take of a previous edge is held pending and taken at the next eligible cycle.

Reset
REQ-024 SHALL: on reset=0: state RUN, irq_pending=0, IRQ_q=0, StallCnt=0; outputs then PC_Write=1, IFID_Write=1, all flush/forward/IRQ_Take 0 given idle inputs.
REQ-025 SHALL: reset asserted during STALL abandons the remaining stall cycle immediately.

Configuration
REQ-026 SHALL: with HAZ_PERF_CNT_EN defined, StallCnt increments by 1 each stall cycle and saturates at 16'hFFFF; without it StallCnt is constant 0 and no counter flops exist.

Structure
REQ-027 SHALL: shared package pipeline_ctrl_pkg holds the FSM state enum, register-index width (5) and StallCnt width (16).
REQ-028 SHALL: one combinational sub-module hazard_match computes the match and stall length (0/1/2) per REQ-012..015.

Verification
REQ-029 SHALL: EX_MemRd=1, EX_RegWr=1, EX_WrReg=8, ID_rs=8, ID_Branch=0 -> one cycle PC_Write=0, IDEX_Flush=1, then PC_Write=1.
REQ-030 SHALL: EX load to reg 9, ID beq with ID_rt=9 -> exactly two stall cycles (second in STALL), StallCnt +2 with macro.
REQ-031 SHALL: MEM_RegWr=1, MEM_MemRd=0, MEM_WrReg=4, ID_rs=4, ID_rt=4 -> ForwardC=ForwardD=1, no stall; MEM_WrReg=0 -> both 0.
REQ-032 SHALL: ID_BranchTaken=1 with no hazard -> IFID_Flush=1 one cycle; same with simultaneous EX-ALU hazard -> stall, IFID_Flush=0.
REQ-033 SHALL: IRQ rises during a 2-cycle stall -> IRQ_Take pulses in first RUN cycle without flush, IFID_Flush=IDEX_Flush=1 that cycle; held IRQ=1 gives no second pulse.
REQ-034 SHALL: reset=0 asserted mid-STALL with irq_pending=1 -> outputs return to reset values asynchronously, no IRQ_Take after release.
